// File: rtl/apb3_traffic_pkg.sv
// Shared types and the data pattern used by the APB3 traffic sequencer.
// The same pattern generates write data and the expected read data.
package apb3_traffic_pkg;

   typedef enum logic [1:0] {
      MODE_WR_THEN_RD  = 2'd0,
      MODE_WR_ONLY     = 2'd1,
      MODE_RD_ONLY     = 2'd2,
      MODE_INTERLEAVED = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_POST,
      ST_DONE
   } state_e;

   localparam int unsigned PatternWidth = 64;

   function automatic logic [PatternWidth-1:0] pattern(input logic [PatternWidth-1:0] seed,
                                                       input logic [PatternWidth-1:0] index);
      return seed ^ index;
   endfunction

endpackage

// File: rtl/apb3_ui_timer.sv
// Gap timer for the PRE and POST idle phases. While load_i is high it holds
// the preload; once load_i drops it counts down to zero and stays there.
module apb3_ui_timer #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             expired_o
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i)               count_q <= '0;
      else if (load_i)           count_q <= load_val_i;
      else if (count_q != '0)    count_q <= count_q - Width'(1);
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/apb3_traffic_sequencer.sv
// Command-side traffic generator for an APB3 requester: bursts of writes and/or
// reads with programmable idle gaps, read-data checking and completion counters.
module apb3_traffic_sequencer
   import apb3_traffic_pkg::*;
#(
   parameter int unsigned          TransfersNum      = 8,
   parameter int unsigned          AddrWidth         = 20,
   parameter int unsigned          DataWidth         = 32,
   parameter logic [AddrWidth-1:0] BaseAddress       = '0,
   parameter logic [DataWidth-1:0] DataSeed          = DataWidth'(32'hA5A5_0000),
   parameter int unsigned          PreTransactionUI  = 2,
   parameter int unsigned          PostTransactionUI = 8,
   parameter int unsigned          Back2BackNum      = 2,
   localparam int unsigned         CW                = $clog2(TransfersNum + 1)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 go_i,
   input  logic [1:0]           mode_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic                 req_write_o,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [DataWidth-1:0] req_wdata_o,
   input  logic                 rsp_valid_i,
   input  logic [DataWidth-1:0] rsp_rdata_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CW-1:0]        count_writes_o,
   output logic [CW-1:0]        count_reads_o,
   output logic [7:0]           mismatch_count_o
);

   localparam int unsigned OW     = $clog2(2 * TransfersNum + 1);
   localparam int unsigned IW     = (TransfersNum > 1) ? $clog2(TransfersNum) : 1;
   localparam int unsigned BW     = (Back2BackNum > 1) ? $clog2(Back2BackNum) : 1;
   localparam int unsigned GapMax = (PreTransactionUI > PostTransactionUI) ? PreTransactionUI
                                                                          : PostTransactionUI;
   localparam int unsigned TW     = (GapMax > 1) ? $clog2(GapMax) : 1;
   localparam logic [TW-1:0] PreLoad  = (PreTransactionUI == 0)  ? '0 : TW'(PreTransactionUI - 1);
   localparam logic [TW-1:0] PostLoad = (PostTransactionUI == 0) ? '0 : TW'(PostTransactionUI - 1);
   localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(DataWidth / 8);

   state_e               state_q;
   mode_e                mode_q;
   logic [OW-1:0]        op_q, op_nxt, total_ops;
   logic [BW-1:0]        burst_q;
   logic                 req_valid_q, req_write_q, busy_q, done_q;
   logic [AddrWidth-1:0] req_addr_q;
   logic [DataWidth-1:0] req_wdata_q, exp_data, issue_data;
   logic [CW-1:0]        cw_q, cr_q;
   logic [7:0]           mis_q;
   logic [IW:0]          cur_dec, issue_dec;
   logic                 issue_zero, last_op, burst_more, rd_bad, tmr_load, tmr_expired;
   logic [TW-1:0]        tmr_val;

   // Op number -> {is_write, index} for the active run mode.
   function automatic logic [IW:0] decode(input mode_e m, input logic [OW-1:0] op);
      logic          wr;
      logic [OW-1:0] ix;
      case (m)
         MODE_WR_THEN_RD: begin
            wr = (op < OW'(TransfersNum));
            ix = wr ? op : op - OW'(TransfersNum);
         end
         MODE_WR_ONLY: begin wr = 1'b1;   ix = op;      end
         MODE_RD_ONLY: begin wr = 1'b0;   ix = op;      end
         default:      begin wr = ~op[0]; ix = op >> 1; end
      endcase
      return {wr, ix[IW-1:0]};
   endfunction

   always_comb begin
      op_nxt     = op_q + OW'(1);
      total_ops  = (mode_q == MODE_WR_ONLY || mode_q == MODE_RD_ONLY) ? OW'(TransfersNum)
                                                                      : OW'(2 * TransfersNum);
      cur_dec    = decode(mode_q, op_q);
      last_op    = (op_nxt == total_ops);
      burst_more = (burst_q != BW'(Back2BackNum - 1)) && !last_op;
      exp_data   = DataWidth'(pattern(PatternWidth'(DataSeed), PatternWidth'(cur_dec[IW-1:0])));
      rd_bad     = (mode_q == MODE_WR_THEN_RD || mode_q == MODE_INTERLEAVED) &&
                   !cur_dec[IW] && (rsp_rdata_i != exp_data);
      // Command fields are staged from whichever op the next ISSUE will carry.
      issue_dec  = cur_dec;
      issue_zero = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            issue_dec  = decode(mode_e'(mode_i), '0);
            issue_zero = !go_i;
         end
         ST_WAIT_RSP: issue_dec = decode(mode_q, op_nxt);
         default: ;
      endcase
      issue_data = DataWidth'(pattern(PatternWidth'(DataSeed), PatternWidth'(issue_dec[IW-1:0])));
      // Timer holds its preload outside the gap it is timing.
      tmr_load   = (state_q != ST_PRE && state_q != ST_POST) || (state_q == ST_POST && tmr_expired);
      tmr_val    = (state_q == ST_WAIT_RSP && PostTransactionUI != 0) ? PostLoad : PreLoad;
   end

   apb3_ui_timer #(.Width(TW)) u_timer (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else if (state_q != ST_ISSUE) begin
         req_write_q <= !issue_zero && issue_dec[IW];
         req_addr_q  <= issue_zero ? '0 : BaseAddress + AddrWidth'(issue_dec[IW-1:0]) * AddrStep;
         req_wdata_q <= (issue_zero || !issue_dec[IW]) ? '0 : issue_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_WR_THEN_RD;
         op_q        <= '0;
         burst_q     <= '0;
         req_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cw_q        <= '0;
         cr_q        <= '0;
         mis_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (go_i) begin
               mode_q  <= mode_e'(mode_i);
               op_q    <= '0;
               burst_q <= '0;
               cw_q    <= '0;
               cr_q    <= '0;
               mis_q   <= '0;
               done_q  <= 1'b0;
               busy_q  <= 1'b1;
               if (PreTransactionUI == 0) begin
                  state_q     <= ST_ISSUE;
                  req_valid_q <= 1'b1;
               end else state_q <= ST_PRE;
            end
            ST_PRE: if (tmr_expired) begin
               state_q     <= ST_ISSUE;
               req_valid_q <= 1'b1;
            end
            ST_ISSUE: if (req_ready_i) begin
               state_q     <= ST_WAIT_RSP;
               req_valid_q <= 1'b0;
            end
            ST_WAIT_RSP: if (rsp_valid_i) begin
               op_q <= op_nxt;
               if (cur_dec[IW]) cw_q <= cw_q + CW'(1);
               else             cr_q <= cr_q + CW'(1);
               if (rd_bad && mis_q != 8'hFF) mis_q <= mis_q + 8'd1;
               if (burst_more) begin
                  burst_q     <= burst_q + BW'(1);
                  state_q     <= ST_ISSUE;
                  req_valid_q <= 1'b1;
               end else begin
                  burst_q <= '0;
                  if (PostTransactionUI != 0) state_q <= ST_POST;
                  else if (last_op) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else if (PreTransactionUI == 0) begin
                     state_q     <= ST_ISSUE;
                     req_valid_q <= 1'b1;
                  end else state_q <= ST_PRE;
               end
            end
            ST_POST: if (tmr_expired) begin
               if (op_q == total_ops) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (PreTransactionUI == 0) begin
                  state_q     <= ST_ISSUE;
                  req_valid_q <= 1'b1;
               end else state_q <= ST_PRE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_valid_o      = req_valid_q;
   assign req_write_o      = req_write_q;
   assign req_addr_o       = req_addr_q;
   assign req_wdata_o      = req_wdata_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign count_writes_o   = cw_q;
   assign count_reads_o    = cr_q;
   assign mismatch_count_o = mis_q;

endmodule

// File: tb/tb_apb3_traffic_sequencer.sv
// Directed bench: a default-parameter sequencer against a memory-echo responder,
// plus a no-gap, 3-deep-burst instance for back-to-back timing.
module tb_apb3_traffic_sequencer;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic        rst;
   logic        a_go, a_valid, a_ready, a_write, a_rsp, a_stray, a_busy, a_done;
   logic [1:0]  a_mode;
   logic [19:0] a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic [3:0]  a_cw, a_cr;
   logic [7:0]  a_mis;

   logic        b_go, b_valid, b_ready, b_write, b_rsp, b_busy, b_done;
   logic [1:0]  b_mode;
   logic [19:0] b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic [3:0]  b_cw, b_cr;
   logic [7:0]  b_mis;

   apb3_traffic_sequencer dut_a (
      .clk_i(clk), .reset_i(rst), .go_i(a_go), .mode_i(a_mode),
      .req_valid_o(a_valid), .req_ready_i(a_ready), .req_write_o(a_write),
      .req_addr_o(a_addr), .req_wdata_o(a_wdata),
      .rsp_valid_i(a_rsp | a_stray), .rsp_rdata_i(a_rdata),
      .busy_o(a_busy), .done_o(a_done), .count_writes_o(a_cw),
      .count_reads_o(a_cr), .mismatch_count_o(a_mis)
   );

   apb3_traffic_sequencer #(
      .Back2BackNum(3), .PreTransactionUI(0), .PostTransactionUI(0)
   ) dut_b (
      .clk_i(clk), .reset_i(rst), .go_i(b_go), .mode_i(b_mode),
      .req_valid_o(b_valid), .req_ready_i(b_ready), .req_write_o(b_write),
      .req_addr_o(b_addr), .req_wdata_o(b_wdata),
      .rsp_valid_i(b_rsp), .rsp_rdata_i(b_rdata),
      .busy_o(b_busy), .done_o(b_done), .count_writes_o(b_cw),
      .count_reads_o(b_cr), .mismatch_count_o(b_mis)
   );

   typedef struct packed {logic wr; logic [3:0] idx;} op_t;

   int          n_cmp = 0, n_bad = 0, cyc = 0;
   int          a_delay, stall_at, stall_left, cmd_no, corrupt_idx;
   logic        corrupt_en;
   logic [31:0] mem [16];
   op_t         log_q[$];
   int          hs_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory-echo responder for dut_a with optional stall and read corruption.
   initial begin : resp_a
      logic        cap_w;
      logic [3:0]  cap_i;
      logic [31:0] cap_d;
      a_ready = 1'b1; a_rsp = 1'b0; a_rdata = '0;
      forever begin
         @(negedge clk);
         if (a_valid && cmd_no + 1 == stall_at && stall_left > 0) begin
            a_ready = 1'b0;
            stall_left--;
            chk("t3_stall_addr",  64'(a_addr),  64'h4);
            chk("t3_stall_wdata", 64'(a_wdata), 64'hA5A5_0001);
            chk("t3_stall_write", 64'(a_write), 64'h1);
            chk("t3_stall_cw",    64'(a_cw),    64'h1);
         end else if (a_valid) begin
            a_ready = 1'b1;
            cmd_no++;
            cap_w = a_write; cap_i = a_addr[5:2]; cap_d = a_wdata;
            log_q.push_back(op_t'{cap_w, cap_i});
            @(posedge clk);
            repeat (a_delay - 1) @(posedge clk);
            #1;
            if (cap_w) mem[cap_i] = cap_d;
            else a_rdata = mem[cap_i] ^ ((corrupt_en && cap_i == 4'(corrupt_idx)) ? 32'h1 : 32'h0);
            a_rsp = 1'b1;
            @(posedge clk);
            #1 a_rsp = 1'b0;
         end else a_ready = 1'b1;
      end
   end

   initial begin : resp_b
      b_rsp = 1'b0;
      forever begin
         @(negedge clk);
         if (b_valid) begin
            hs_q.push_back(cyc + 1);
            @(posedge clk);
            #1 b_rsp = 1'b1;
            @(posedge clk);
            #1 b_rsp = 1'b0;
         end
      end
   end

   task automatic clear_run();
      cmd_no = 0; stall_at = 0; stall_left = 0; corrupt_en = 1'b0; corrupt_idx = 0;
      log_q.delete();
   endtask

   task automatic pulse_go_a(input logic [1:0] m);
      @(posedge clk); #1;
      a_go = 1'b1; a_mode = m;
      @(posedge clk); #1;
      a_go = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int n = 0;
      while (!a_done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, 64'(a_done), 64'h1);
      chk({tag, "_busy"}, 64'(a_busy), 64'h0);
   endtask

   task automatic check_counts(input string tag, input int w, input int r, input int m);
      chk({tag, "_cw"},  64'(a_cw),  64'(w));
      chk({tag, "_cr"},  64'(a_cr),  64'(r));
      chk({tag, "_mis"}, 64'(a_mis), 64'(m));
   endtask

   task automatic check_order(input string tag, input logic interleaved);
      op_t e;
      chk({tag, "_nops"}, 64'(log_q.size()), 64'd16);
      for (int k = 0; k < 16 && k < log_q.size(); k++) begin
         e.wr  = interleaved ? (k % 2 == 0) : (k < 8);
         e.idx = interleaved ? 4'(k / 2) : 4'(k % 8);
         chk({tag, "_order"}, 64'(log_q[k]), 64'(e));
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      rst = 1'b1; a_go = 1'b0; a_mode = '0; a_stray = 1'b0;
      b_go = 1'b0; b_mode = '0; b_ready = 1'b1; b_rdata = '0;
      a_delay = 1;
      clear_run();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(a_valid), 64'h0);
      chk("rst_busy",  64'(a_busy),  64'h0);
      chk("rst_done",  64'(a_done),  64'h0);
      chk("rst_req",   64'({a_write, a_addr, a_wdata}), 64'h0);
      check_counts("rst", 0, 0, 0);
      rst = 1'b0;

      // 1: write-then-read, go latency
      @(posedge clk); #1;
      a_go = 1'b1; a_mode = 2'd0; n = 0;
      do begin
         @(posedge clk); #1;
         a_go = 1'b0;
         n++;
      end while (!a_valid && n < 20);
      chk("t1_latency", 64'(n), 64'd3);
      chk("t1_addr0",   64'(a_addr), 64'h0);
      chk("t1_wdata0",  64'(a_wdata), 64'hA5A5_0000);
      wait_done_a("t1");
      check_counts("t1", 8, 8, 0);
      check_order("t1", 1'b0);

      // 2: interleaved with read index 5 corrupted
      clear_run();
      corrupt_en = 1'b1; corrupt_idx = 5;
      pulse_go_a(2'd3);
      chk("t2_done_drop", 64'(a_done), 64'h0);
      chk("t2_busy",      64'(a_busy), 64'h1);
      wait_done_a("t2");
      check_counts("t2", 8, 8, 1);
      check_order("t2", 1'b1);

      // 3: second command stalled four cycles
      clear_run();
      stall_at = 2; stall_left = 4;
      pulse_go_a(2'd0);
      wait_done_a("t3");
      chk("t3_stalls", 64'(stall_left), 64'h0);
      check_counts("t3", 8, 8, 0);

      // 4: back-to-back bursts with no gaps, write only
      @(posedge clk); #1;
      b_go = 1'b1; b_mode = 2'd1;
      @(posedge clk); #1;
      b_go = 1'b0; n = 0;
      while (!b_done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t4_done", 64'(b_done), 64'h1);
      chk("t4_nhs",  64'(hs_q.size()), 64'd8);
      for (int i = 1; i < hs_q.size(); i++) chk("t4_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'd2);
      chk("t4_cw",   64'(b_cw), 64'd8);
      chk("t4_cr",   64'(b_cr), 64'd0);

      // 5: reset while waiting for a response
      clear_run();
      a_delay = 6;
      pulse_go_a(2'd0);
      n = 0;
      while (cmd_no < 3 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_reached", 64'(cmd_no), 64'd3);
      @(posedge clk); #1;
      chk("t5_wait_valid", 64'(a_valid), 64'h0);
      chk("t5_wait_cw",    64'(a_cw),    64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_rst_valid", 64'(a_valid), 64'h0);
      chk("t5_rst_busy",  64'(a_busy),  64'h0);
      check_counts("t5_rst", 0, 0, 0);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      a_delay = 1;
      clear_run();
      pulse_go_a(2'd0);
      wait_done_a("t5");
      check_counts("t5", 8, 8, 0);
      check_order("t5", 1'b0);

      // 6: read only over stale memory, stray response and go pulses while busy
      clear_run();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      pulse_go_a(2'd2);
      a_stray = 1'b1;
      @(posedge clk); #1;
      a_stray = 1'b0;
      a_go = 1'b1; a_mode = 2'd3;
      @(posedge clk); #1;
      a_go = 1'b0;
      chk("t6_busy", 64'(a_busy), 64'h1);
      repeat (30) @(posedge clk);
      #1;
      a_go = 1'b1; a_mode = 2'd1;
      @(posedge clk); #1;
      a_go = 1'b0;
      wait_done_a("t6");
      check_counts("t6", 0, 8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
